// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq -- iterative multiply/divide sequencer owning the HI/LO pair.
//
// Executes MULT / MULTU (shift-add, one multiplier bit per clock) and
// DIV / DIVU (restoring, one quotient bit per clock) on operand magnitudes,
// then applies sign correction in a final FIX cycle while committing HI/LO.
// Start sampled at edge 0 -> HI/LO and done visible after edge WIDTH+1.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   launch operation (honoured in IDLE only, blocked by flush)
//   op     in   2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   a      in   rs operand (multiplicand / dividend)
//   b      in   rt operand (multiplier / divisor)
//   flush  in   abort in-flight operation, HI/LO untouched
//   mthi   in   write wdata to HI (IDLE with start=0 only)
//   mtlo   in   write wdata to LO (IDLE with start=0 only)
//   wdata  in   MTHI/MTLO data
//   busy   out  high while an operation is in flight
//   done   out  one-cycle pulse in the cycle after HI/LO commit
//   hi     out  HI register
//   lo     out  LO register
// ---------------------------------------------------------------------------
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Conditional two's-complement negation used for sign correction.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? -v : v;
    endfunction

    // Control state
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Datapath state (no reset needed: always loaded at launch)
    logic             r_is_div;
    logic             r_neg_q;     // negate product / quotient
    logic             r_neg_r;     // negate remainder (dividend sign)
    logic             r_bzero;
    logic [WIDTH-1:0] r_a_orig;
    logic [WIDTH-1:0] r_b;         // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0] r_rem;       // upper product half / partial remainder
    logic [WIDTH-1:0] r_q;         // multiplier->lower product / dividend->quotient

    // Operand conditioning: signed ops take magnitudes, unsigned pass through.
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_launch;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = cond_neg_w(a, w_a_neg);
    assign w_b_mag  = cond_neg_w(b, w_b_neg);
    assign w_launch = (r_state == S_IDLE) && start && !flush;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole {carry, rem, q} right.
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : '0);

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The true difference is always below
    // the divisor, so WIDTH bits hold it exactly.
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;
    assign w_div_shift = {r_rem, r_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

    // Final results with sign correction. Divide-by-zero overrides the
    // iterative result so HI carries the original (unsigned-view) dividend.
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    assign w_prod_fix = cond_neg_2w({r_rem, r_q}, r_neg_q);
    assign w_quo_fix  = cond_neg_w(r_q, r_neg_q);
    assign w_rem_fix  = cond_neg_w(r_rem, r_neg_r);
    assign w_hi_res   = r_is_div ? (r_bzero ? r_a_orig : w_rem_fix)
                                 : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_res   = r_is_div ? (r_bzero ? '1 : w_quo_fix)
                                 : w_prod_fix[WIDTH-1:0];

    // Sequencer FSM and HI/LO ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else if (!start) begin
                        // start has priority over MTHI/MTLO, even when flushed
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Iterative datapath
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_bzero  <= (b == '0);
            r_a_orig <= a;
            r_rem    <= '0;
            r_b      <= op[1] ? w_b_mag : w_a_mag;
            r_q      <= op[1] ? w_a_mag : w_b_mag;
        end else if (r_state == S_RUN) begin
            if (r_is_div) begin
                if (w_div_ge) begin
                    r_rem <= w_div_sub;
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_div_shift[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_rem <= w_mul_sum[WIDTH:1];
                r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq -- directed and randomized bench for mdu_seq. Expected HI/LO
// come from a 64-bit arithmetic reference model of the instruction set
// semantics (MULT/MULTU/DIV/DIVU including divide-by-zero and overflow).
// ---------------------------------------------------------------------------
module tb_mdu_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        flush = 1'b0;
    logic        mthi  = 1'b0;
    logic        mtlo  = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit / native integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sp;
        logic [63:0] up;
        int          sx, sy;
        sx = x;
        sy = y;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {eh, el} = sp;
            end
            2'b01: begin
                up = {32'b0, x} * {32'b0, y};
                {eh, el} = up;
            end
            2'b10: begin
                if (y == 0) begin
                    el = 32'hFFFF_FFFF; eh = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'h0;
                end else begin
                    el = 32'(sx / sy);
                    eh = 32'(sx % sy);
                end
            end
            default: begin
                if (y == 0) begin
                    el = 32'hFFFF_FFFF; eh = x;
                end else begin
                    el = x / y;
                    eh = x % y;
                end
            end
        endcase
    endfunction

    // Launch one operation and check latency, busy window, done pulse and
    // result. Optional disturbances: mid-run start/mthi/mtlo pulses, and an
    // MTLO issued in the same cycle as start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit disturb, input bit mt_same);
        logic [31:0] eh, el, lo_before;
        int cycles, busy_cnt;
        model(o, x, y, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        lo_before = lo;
        if (mt_same) begin
            mtlo  = 1'b1;
            wdata = 32'h5555_AAAA;
        end
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        chk({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
        if (mt_same) chk({tag, " lo_not_written_with_start"}, lo, lo_before);
        cycles   = 0;
        busy_cnt = 1;
        while (!done && cycles < 100) begin
            if (disturb && cycles == 5) begin
                start = 1'b1; op = ~o; mthi = 1'b1; mtlo = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            cycles++;
            if (busy) busy_cnt++;
        end
        chk({tag, " latency"}, 32'(cycles), 32'd33);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [1:0]  ro;
        logic [31:0] rx, ry, rw;

        // Reset state
        #12;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases
        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        chk("mult_m3x5 hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_m3x5 lo_const", lo, 32'hFFFF_FFF1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max hi_const", hi, 32'hFFFF_FFFE);
        chk("multu_max lo_const", lo, 32'h0000_0001);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_m7d2 lo_const", lo, 32'hFFFF_FFFD);
        chk("div_m7d2 hi_const", hi, 32'hFFFF_FFFF);
        run_op("divu_by0", 2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("divu_by0 lo_const", lo, 32'hFFFF_FFFF);
        chk("divu_by0 hi_const", hi, 32'd7);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf lo_const", lo, 32'h8000_0000);
        chk("div_ovf hi_const", hi, 32'h0);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);

        // Preload via MTHI/MTLO, then flush a DIVU mid-run
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("preload hi", hi, 32'h1234);
        chk("preload lo", lo, 32'h1234);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy_drop", {31'b0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("flush no_done", 32'(seen), 32'd0);
        chk("flush hi_kept", hi, 32'h1234);
        chk("flush lo_kept", lo, 32'h1234);

        // Flush in IDLE blocks start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("idle_flush blocks_start", {31'b0, busy}, 32'd0);

        // Start/mthi during RUN ignored; start+mtlo in IDLE -> start wins
        run_op("disturbed", 2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b0);
        run_op("start_mtlo", 2'b01, 32'd3, 32'd4, 1'b0, 1'b1);
        chk("start_mtlo lo_const", lo, 32'd12);

        // Asynchronous reset mid-MULT
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst hi", hi, 32'h0);
        chk("async_rst lo", lo, 32'h0);
        chk("async_rst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 1'b0, 1'b0);
        chk("multu_6x7 lo_const", lo, 32'd42);
        chk("multu_6x7 hi_const", hi, 32'd0);

        // Randomized operations and MTHI/MTLO writes against the model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            else if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
            run_op("rand", ro, rx, ry, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                rw = $urandom;
                @(negedge clk);
                mthi = 1'b1; wdata = rw;
                @(posedge clk); #1;
                mthi = 1'b0;
                chk("rand mthi", hi, rw);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the EX stage of the pipelined CPU. Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the HI/LO register pair.
- Signed or unsigned handling of operands follows the same sign/zero-extension convention the datapath uses for immediates.
- Drives `busy` so the hazard unit stalls MFHI/MFLO and any new MDU instruction until the result is committed.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  abort in-flight operation (pipeline flush)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse in the cycle after HI/LO commit
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, internal counter cleared.
  - Reset asserted mid-operation discards the operation; HI/LO go to 0.
- States: IDLE, RUN, FIX. busy = (state != IDLE), registered-equivalent (no combinational path from start).
- Transitions:
  - IDLE -> RUN on start=1 and flush=0. Latches op, sign flags, |a| and |b|, and clears the counter.
  - Signed ops (MULT, DIV) use two's-complement magnitude. Unsigned ops (MULTU, DIVU) use the operands as-is.
  - RUN: one iteration per clock. Multiply is shift-add, one multiplier bit per cycle. Divide is restoring, one quotient bit per cycle.
  - RUN -> FIX after exactly WIDTH iterations.
  - FIX -> IDLE: applies sign correction, writes HI/LO, and sets done=1 for that following cycle only.
- Latency: start sampled at edge 0 -> HI/LO updated at edge WIDTH+1 (33 for default). busy is high for WIDTH+1 cycles.
- Result rules:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product. MULT negates the 2*WIDTH product iff the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder. For DIV, the quotient is negated iff the signs differ, and the remainder takes the sign of the dividend.
  - Divide by zero (DIV or DIVU): normal timing; lo = all ones, hi = original a.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0. No exception.
- flush:
  - In RUN or FIX, flush=1 returns to IDLE at the next edge. HI/LO unchanged, no done pulse.
  - In IDLE, flush=1 blocks start that cycle.
- start while busy: ignored.
- mthi/mtlo:
  - Honoured only in IDLE with start=0. HI and LO can both be written in the same cycle.
  - Ignored while busy and ignored when start=1; start has priority.
  - Written value is visible on hi/lo after the edge.
- a, b and op may change after the start cycle without affecting the operation.

Test Plan:
- Reset then MULT, a=0xFFFFFFFD (-3), b=5 -> busy high for 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at edge 33; done one cycle.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload via mthi=mtlo=1, wdata=0x1234. Start DIVU 100/7, assert flush at cycle 10 -> busy drops next cycle; hi=lo=0x1234; no done.
- During RUN: pulse start with a different op and pulse mthi -> both ignored; original result is committed. In IDLE, start+mtlo in the same cycle -> only start takes effect.
- Assert rst_n=0 at cycle 15 of a MULT -> hi=lo=0, busy=0 immediately. A new MULTU 6*7 afterwards -> lo=42, hi=0.
